// File: rtl/cordic_phase_gen_if.sv
// cordic_phase_gen_if: control/sample bundle between a controller and the CORDIC phase generator
interface cordic_phase_gen_if #(parameter int PHASE_W = 32);
  logic en;
  logic phase_clr;
  logic fcw_wr;
  logic [PHASE_W-1:0] fcw_data;
  logic signed [15:0] z;
  logic z_valid;
  logic flip_d;
  logic valid_d;
  modport master(output en, phase_clr, fcw_wr, fcw_data, input z, z_valid, flip_d, valid_d);
  modport slave(input en, phase_clr, fcw_wr, fcw_data, output z, z_valid, flip_d, valid_d);
endinterface

// File: rtl/cordic_phase_gen.sv
// cordic_phase_gen: NCO accumulator folding phase into [-pi/2, pi/2) as Q2.14 z for a pipelined CORDIC.
// Define CORDIC_PHASE_DITHER_EN to add LFSR phase dither before truncation.
module cordic_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int LAT = 14
) (
  input logic clk,
  input logic rst,
  cordic_phase_gen_if.slave bus
);
  logic [PHASE_W-1:0] acc, fcw;
  logic [15:0] p;
  logic signed [15:0] ps;
  logic signed [31:0] prod;
  logic flip_n, flip;
  logic [LAT-1:0] vd, fd;
`ifdef CORDIC_PHASE_DITHER_EN
  logic [15:0] lfsr;
  logic [PHASE_W-1:0] acc_d;
  assign acc_d = acc + PHASE_W'(lfsr[PHASE_W-17:0]);
  assign p = acc_d[PHASE_W-1 -: 16];
  always_ff @(posedge clk or posedge rst)
    if (rst) lfsr <= 16'hACE1;
    else if (bus.en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
`else
  assign p = acc[PHASE_W-1 -: 16];
`endif
  // quadrants 1 and 2 are rotated by pi; the sign flip is undone on x/y downstream
  assign flip_n = p[15] ^ p[14];
  assign ps = $signed(flip_n ? p - 16'h8000 : p);
  assign prod = $signed({{16{ps[15]}}, ps}) * 32'sd25736 + 32'sd8192;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      fcw <= '0;
      bus.z <= '0;
      bus.z_valid <= 1'b0;
      flip <= 1'b0;
      vd <= '0;
      fd <= '0;
    end else begin
      if (bus.fcw_wr) fcw <= bus.fcw_data;
      if (bus.phase_clr) acc <= '0;
      else if (bus.en) acc <= acc + fcw;
      if (bus.en) begin
        bus.z <= 16'(prod >>> 14);
        flip <= flip_n;
      end
      bus.z_valid <= bus.en;
      vd <= {vd[LAT-2:0], bus.z_valid};
      fd <= {fd[LAT-2:0], flip};
    end
  end
  assign bus.valid_d = vd[LAT-1];
  assign bus.flip_d = fd[LAT-1];
endmodule

// File: tb/tb_cordic_phase_gen.sv
// tb_cordic_phase_gen: directed vector table plus reset/pulse sequences for cordic_phase_gen
module tb_cordic_phase_gen;
  localparam int LAT = 14;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cordic_phase_gen_if #(.PHASE_W(32)) bus();
  cordic_phase_gen #(.PHASE_W(32), .LAT(LAT)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic en, clr, wr;
    logic [31:0] data;
    int ez;
    logic ev, ef;
  } vec_t;
  vec_t v[22];
  logic hv[$], hf[$];
  int total = 0, bad = 0;
  function automatic vec_t mk(logic en, logic clr, logic wr, logic [31:0] data, int ez, logic ev, logic ef);
    vec_t r;
    r.en = en; r.clr = clr; r.wr = wr; r.data = data; r.ez = ez; r.ev = ev; r.ef = ef;
    return r;
  endfunction
  task automatic chk(input string n, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic flush_hist();
    hv.delete();
    hf.delete();
    for (int i = 0; i < LAT; i++) begin
      hv.push_back(1'b0);
      hf.push_back(1'b0);
    end
  endtask
  // expected delayed outputs come from the history of expected z_valid/flip, LAT rows back
  task automatic run_row(input vec_t r, input string tag);
    bus.en = r.en; bus.phase_clr = r.clr; bus.fcw_wr = r.wr; bus.fcw_data = r.data;
    @(posedge clk);
    #1;
    chk({tag, "_z"}, int'(bus.z), r.ez);
    chk({tag, "_zv"}, int'(bus.z_valid), int'(r.ev));
    hv.push_back(r.ev);
    hf.push_back(r.ef);
    chk({tag, "_vd"}, int'(bus.valid_d), int'(hv[hv.size()-1-LAT]));
    chk({tag, "_fd"}, int'(bus.flip_d), int'(hf[hf.size()-1-LAT]));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    int lat_seen;
    bus.en = 0; bus.phase_clr = 0; bus.fcw_wr = 0; bus.fcw_data = '0;
    v[0] = mk(0, 0, 1, 32'h4000_0000, 0, 0, 0);
    v[1] = mk(1, 0, 0, 0, 0, 1, 0);
    v[2] = mk(1, 0, 0, 0, -25736, 1, 1);
    v[3] = mk(1, 0, 0, 0, 0, 1, 1);
    v[4] = mk(1, 0, 0, 0, -25736, 1, 0);
    v[5] = mk(0, 0, 0, 0, -25736, 0, 0);
    v[6] = mk(0, 0, 0, 0, -25736, 0, 0);
    v[7] = mk(0, 0, 0, 0, -25736, 0, 0);
    v[8] = mk(1, 0, 0, 0, 0, 1, 0);
    v[9] = mk(1, 0, 0, 0, -25736, 1, 1);
    v[10] = mk(0, 1, 1, 32'h0100_0000, -25736, 0, 1);
    v[11] = mk(1, 0, 0, 0, 0, 1, 0);
    v[12] = mk(1, 0, 0, 0, 402, 1, 0);
    v[13] = mk(1, 0, 0, 0, 804, 1, 0);
    v[14] = mk(1, 0, 0, 0, 1206, 1, 0);
    v[15] = mk(1, 1, 0, 0, 1609, 1, 0);
    v[16] = mk(1, 0, 0, 0, 0, 1, 0);
    v[17] = mk(1, 0, 0, 0, 402, 1, 0);
    v[18] = mk(0, 1, 1, 32'h3FFF_0000, 402, 0, 0);
    v[19] = mk(1, 0, 0, 0, 0, 1, 0);
    v[20] = mk(1, 0, 0, 0, 25734, 1, 0);
    v[21] = mk(1, 0, 0, 0, -3, 1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", int'(bus.z), 0);
    chk("rst_zv", int'(bus.z_valid), 0);
    chk("rst_vd", int'(bus.valid_d), 0);
    chk("rst_fd", int'(bus.flip_d), 0);
    rst = 1'b0;
    flush_hist();
    for (int i = 0; i < 22; i++) run_row(v[i], $sformatf("row%0d", i));
    for (int i = 0; i < LAT; i++) run_row(mk(0, 0, 0, 0, -3, 0, 1), "tail");
    run_row(mk(0, 1, 1, 32'h8000_0000, -3, 0, 1), "p_clr");
    run_row(mk(1, 0, 0, 0, 0, 1, 0), "p_pre");
    for (int i = 0; i < 20; i++) run_row(mk(0, 0, 0, 0, 0, 0, 0), "p_idle");
    run_row(mk(1, 0, 0, 0, 0, 1, 1), "pulse");
    lat_seen = -1;
    for (int n = 1; n <= LAT + 5; n++) begin
      run_row(mk(0, 0, 0, 0, 0, 0, 1), "p_wait");
      if (bus.valid_d && lat_seen < 0) lat_seen = n;
    end
    chk("pulse_lat", lat_seen, LAT);
    run_row(mk(0, 0, 1, 32'h4000_0000, 0, 0, 1), "r_wr");
    for (int k = 0; k < 16; k++)
      run_row(mk(1, 0, 0, 0, (k % 2) ? -25736 : 0, 1, (k % 4 == 1) || (k % 4 == 2)), "r_run");
    #2;
    rst = 1'b1;
    #1;
    chk("arst_z", int'(bus.z), 0);
    chk("arst_zv", int'(bus.z_valid), 0);
    chk("arst_vd", int'(bus.valid_d), 0);
    chk("arst_fd", int'(bus.flip_d), 0);
    #1;
    rst = 1'b0;
    flush_hist();
    for (int i = 0; i < LAT + 2; i++) run_row(mk(0, 0, 0, 0, 0, 0, 0), "r_flush");
    run_row(mk(1, 0, 0, 0, 0, 1, 0), "r_after");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
